pe_mac_cell: RTL and testbench

PE_MAC_CELL -- requirements
Module: pe_mac_cell

---
 rtl/pe_mac_cell.sv | 156 +++++++++++++++
 tb/tb_pe_mac_cell.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_cell.sv
// pe_mac_cell: systolic-array PE supporting weight-stationary (WS) and output-stationary (OS) dataflows.
// Define PE_SAT_EN to clamp sums and raise the sticky ovf flag; otherwise sums wrap and ovf stays 0.
module pe_mac_cell #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int MUL_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_flow,
  input  logic                         load,
  input  logic                         drain,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] left,
  input  logic signed [ACC_WIDTH-1:0]  up,
  output logic signed [DATA_WIDTH-1:0] right,
  output logic                         right_valid,
  output logic signed [ACC_WIDTH-1:0]  down,
  output logic                         down_valid,
  output logic                         busy,
  output logic                         ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic {OS_ACC = 1'b0, OS_FWD = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic                          df_q;
  logic                          modeChange;
  logic signed [DATA_WIDTH-1:0]  weight_q, weight_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   down_q, down_d;
  logic                          downValid_q, downValid_d;
  logic                          ovf_q, ovf_d;
  logic signed [DATA_WIDTH-1:0]  right_q;
  logic                          rightValid_q;

  logic signed [PW-1:0]          mul_q [MUL_LAT];
  logic [MUL_LAT-1:0]            prodValid_q;

  logic signed [DATA_WIDTH-1:0]  opB;
  logic signed [PW-1:0]          mulNew;
  logic signed [ACC_WIDTH-1:0]   prodAdd, dnOpA, dnSum, acSum;
  logic                          dnClamp, acClamp;

  // Returns {clamped, result}; the clamped bit can only be set when saturation is built in.
  function automatic logic [ACC_WIDTH:0] addClamp(input logic signed [ACC_WIDTH-1:0] a,
                                                  input logic signed [ACC_WIDTH-1:0] b);
`ifdef PE_SAT_EN
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    return {1'b0, s[ACC_WIDTH-1:0]};
`else
    return {1'b0, a + b};
`endif
  endfunction

  assign modeChange = data_flow ^ df_q;
  assign opB        = data_flow ? weight_q : up[DATA_WIDTH-1:0];
  assign mulNew     = PW'(left) * PW'(opB);
  assign prodAdd    = prodValid_q[MUL_LAT-1] ? ACC_WIDTH'(mul_q[MUL_LAT-1]) : '0;
  assign dnOpA      = data_flow ? up : acc_q;

  assign {dnClamp, dnSum} = addClamp(dnOpA, prodAdd);
  assign {acClamp, acSum} = addClamp(acc_q, prodAdd);

  // A mode switch flushes in-flight products so they never leak into the other dataflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) mul_q[i] <= '0;
      prodValid_q <= '0;
    end else begin
      mul_q[0]       <= mulNew;
      prodValid_q[0] <= in_valid & ~modeChange;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_q[i]       <= mul_q[i-1];
        prodValid_q[i] <= prodValid_q[i-1] & ~modeChange;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    weight_d    = weight_q;
    down_d      = down_q;
    downValid_d = 1'b0;
    ovf_d       = ovf_q;
    if (modeChange) begin
      acc_d   = '0;
      state_d = OS_ACC;
    end else if (data_flow) begin
      if (load) begin
        if (in_valid) begin
          weight_d    = up[DATA_WIDTH-1:0];
          down_d      = up;
          downValid_d = 1'b1;
        end
      end else begin
        down_d      = dnSum;
        downValid_d = prodValid_q[MUL_LAT-1];
        ovf_d       = ovf_q | dnClamp;
      end
    end else if (state_q == OS_ACC && drain) begin
      // The product landing on the drain edge belongs to the tile being emitted.
      down_d      = dnSum;
      downValid_d = 1'b1;
      acc_d       = '0;
      ovf_d       = ovf_q | dnClamp;
      state_d     = OS_FWD;
    end else begin
      down_d      = up;
      downValid_d = in_valid;
      if (prodValid_q[MUL_LAT-1]) begin
        acc_d = acSum;
        ovf_d = ovf_q | acClamp;
      end
      state_d = drain ? OS_FWD : OS_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OS_ACC;
      df_q         <= 1'b0;
      weight_q     <= '0;
      acc_q        <= '0;
      down_q       <= '0;
      downValid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      right_q      <= '0;
      rightValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      df_q         <= data_flow;
      weight_q     <= weight_d;
      acc_q        <= acc_d;
      down_q       <= down_d;
      downValid_q  <= downValid_d;
      ovf_q        <= ovf_d;
      right_q      <= left;
      rightValid_q <= in_valid;
    end
  end

  assign right       = right_q;
  assign right_valid = rightValid_q;
  assign down        = down_q;
  assign down_valid  = downValid_q;
  assign busy        = (state_q == OS_FWD) && !data_flow;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pe_mac_cell.sv
// tb_pe_mac_cell: directed literal cases plus randomized traffic checked each cycle against a behavioural model.
module tb_pe_mac_cell;

  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int LAT = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 data_flow = 1'b0;
  logic                 load = 1'b0;
  logic                 drain = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] left = '0;
  logic signed [AW-1:0] up = '0;
  logic signed [DW-1:0] right;
  logic                 right_valid;
  logic signed [AW-1:0] down;
  logic                 down_valid;
  logic                 busy;
  logic                 ovf;

  int nCompared = 0;
  int nMismatched = 0;

  pe_mac_cell #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .data_flow(data_flow), .load(load), .drain(drain),
    .in_valid(in_valid), .left(left), .up(up), .right(right), .right_valid(right_valid),
    .down(down), .down_valid(down_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model state: mState 0 = accumulating, 1 = forwarding after a drain.
  int     mState = 0;
  longint mAcc = 0, mWeight = 0, mDown = 0, mRight = 0;
  bit     mDownV = 0, mRightV = 0, mOvf = 0, mPrevDf = 0;
  longint mProdQ[$];
  bit     mPvQ[$];

  function automatic longint fitAcc(input longint v);
    longint hi = (longint'(1) <<< (AW-1)) - 1;
    longint lo = -(longint'(1) <<< (AW-1));
    longint span = longint'(1) <<< AW;
`ifdef PE_SAT_EN
    if (v > hi) begin mOvf = 1; return hi; end
    if (v < lo) begin mOvf = 1; return lo; end
    return v;
`else
    while (v > hi) v -= span;
    while (v < lo) v += span;
    return v;
`endif
  endfunction

  task automatic modelReset();
    mState = 0; mAcc = 0; mWeight = 0; mDown = 0; mRight = 0;
    mDownV = 0; mRightV = 0; mOvf = 0; mPrevDf = 0;
    mProdQ.delete(); mPvQ.delete();
    for (int i = 0; i < LAT; i++) begin mProdQ.push_back(0); mPvQ.push_back(0); end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      longint pOut, b, newP, pAdd;
      bit pvOut, chg;
      chg   = (data_flow != mPrevDf);
      b     = data_flow ? mWeight : longint'($signed(up[DW-1:0]));
      newP  = longint'(left) * b;
      pOut  = mProdQ.pop_front();
      pvOut = mPvQ.pop_front();
      pAdd  = pvOut ? pOut : 0;
      mProdQ.push_back(newP);
      mPvQ.push_back(in_valid && !chg);
      mRight  = longint'(left);
      mRightV = in_valid;
      if (chg) begin
        foreach (mPvQ[i]) mPvQ[i] = 0;
        mAcc = 0; mDownV = 0; mState = 0;
      end else if (data_flow) begin
        if (load) begin
          mDownV = in_valid;
          if (in_valid) begin
            mWeight = longint'($signed(up[DW-1:0]));
            mDown = longint'(up);
          end
        end else begin
          mDown  = fitAcc(longint'(up) + pAdd);
          mDownV = pvOut;
        end
      end else if (mState == 0 && drain) begin
        mDown = fitAcc(mAcc + pAdd); mDownV = 1; mAcc = 0; mState = 1;
      end else begin
        mDown = longint'(up); mDownV = in_valid;
        if (pvOut) mAcc = fitAcc(mAcc + pOut);
        mState = drain ? 1 : 0;
      end
      mPrevDf = data_flow;
    end
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("right", right, mRight);
      checkOutput("right_valid", right_valid, mRightV);
      checkOutput("down_valid", down_valid, mDownV);
      if (mDownV) checkOutput("down", down, mDown);
      checkOutput("busy", busy, (mState == 1 && !data_flow));
      checkOutput("ovf", ovf, mOvf);
    end
  end

  // Drives one cycle of inputs and returns 2 time units after the edge that consumed them.
  task automatic applyStimulus(input bit df, input bit ld, input bit dr, input bit iv,
                               input int lf, input int u);
    data_flow = df; load = ld; drain = dr; in_valid = iv;
    left = DW'(lf); up = AW'(u);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int drainLeft;
    int lf, u;
    bit df;
    #1;
    checkOutput("reset_right", right, 0);
    checkOutput("reset_right_valid", right_valid, 0);
    checkOutput("reset_down", down, 0);
    checkOutput("reset_down_valid", down_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", ovf, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // WS: load weight 5, stream -3, add 100 arriving from above.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 5);
    applyStimulus(1, 0, 0, 1, -3, 0);
    applyStimulus(1, 0, 0, 0, 0, 100);
    checkOutput("ws_basic_down", down, 85);
    checkOutput("ws_basic_valid", down_valid, 1);

    // WS overflow corner: 127*127 on top of the max positive partial sum.
    applyStimulus(1, 1, 0, 1, 0, 127);
    applyStimulus(1, 0, 0, 1, 127, 0);
    applyStimulus(1, 0, 0, 0, 0, 8388607);
`ifdef PE_SAT_EN
    checkOutput("ws_ovf_down", down, 8388607);
    checkOutput("ws_ovf_flag", ovf, 1);
`else
    checkOutput("ws_ovf_down", down, -8372480);
    checkOutput("ws_ovf_flag", ovf, 0);
`endif

    // OS: 3*(2+3+4+5) drained, then two forwarded results.
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) applyStimulus(0, 0, 0, 1, i, 3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("os_drain_down", down, 42);
    checkOutput("os_drain_busy", busy, 1);
    applyStimulus(0, 0, 1, 1, 0, 7);
    checkOutput("os_fwd1_down", down, 7);
    checkOutput("os_fwd1_busy", busy, 1);
    applyStimulus(0, 0, 1, 1, 0, 9);
    checkOutput("os_fwd2_down", down, 9);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("os_exit_busy", busy, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("os_acc_cleared", down, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // OS: most-negative operands squared twice.
    applyStimulus(0, 0, 0, 1, -128, -128);
    applyStimulus(0, 0, 0, 1, -128, -128);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("os_minmin_down", down, 32768);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // OS: last product lands exactly on the drain edge.
    applyStimulus(0, 0, 0, 1, 5, 2);
    applyStimulus(0, 0, 0, 1, 4, 2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("os_late_prod_down", down, 18);

    // Reset asserted while forwarding.
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("fwd_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_down", down, 0);
    checkOutput("midreset_down_valid", down_valid, 0);
    checkOutput("midreset_right_valid", right_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_ovf", ovf, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("post_reset_drain", down, 0);
    checkOutput("post_reset_drain_valid", down_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic across both modes.
    drainLeft = 0;
    df = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) df = ~df;
      lf = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 3))
        0: u = int'($urandom_range(0, 16777215)) - 8388608;
        1: u = ($urandom_range(0, 1) == 1) ? 8388607 - int'($urandom_range(0, 200))
                                            : -8388608 + int'($urandom_range(0, 200));
        default: u = int'($urandom_range(0, 2000)) - 1000;
      endcase
      if (drainLeft == 0 && $urandom_range(0, 11) == 0) drainLeft = int'($urandom_range(1, 4));
      applyStimulus(df, ($urandom_range(0, 7) == 0), (drainLeft > 0),
                    ($urandom_range(0, 3) != 0), lf, u);
      if (drainLeft > 0) drainLeft--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
